// File: rtl/sensor_pkg.sv
// Shared sensor acquisition types and constants for the sampler and fault FSMs.
package sensor_pkg;

    localparam int ADC_BITS       = 12;
    localparam int FRAME_BITS     = 16;
    localparam int DATA_FIRST_IDX = 3;
    localparam int SEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4
    } sampler_state_t;

    function automatic logic is_data_idx(input logic [3:0] k);
        return (k >= 4'(DATA_FIRST_IDX)) &&
               (k < 4'(DATA_FIRST_IDX + ADC_BITS));
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample period counter; tick marks the last cycle of each period.
module sample_tick_gen #(
    parameter int SAMPLE_CYCLES = 800000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/sensor_sampler.sv
// Paced SPI ADC reader producing one sen word per sample period.
// Define SENSOR_SAMPLER_AVG4_EN to average four conversions per tick.
module sensor_sampler
    import sensor_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 800000,
    parameter int SCLK_DIV      = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miso,
    output logic             cs_n,
    output logic             sclk,
    output logic [SEN_W-1:0] sen,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [4:0] EDGE_LAST = 5'(2 * FRAME_BITS - 1);

    sampler_state_t state;
    logic tick;
    logic [DW-1:0] div_cnt;
    logic [4:0] edge_cnt;
    logic [ADC_BITS-1:0] sr;
    logic div_last;

    assign div_last = (div_cnt == DIV_LAST);
    assign busy     = (state != IDLE);

`ifdef SENSOR_SAMPLER_AVG4_EN
    logic [1:0]  conv_cnt;
    logic [13:0] acc;
    logic [13:0] sum_next;

    assign sum_next = acc + 14'(sr);
`endif

    sample_tick_gen #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            sen          <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            div_cnt      <= '0;
            edge_cnt     <= '0;
            sr           <= '0;
`ifdef SENSOR_SAMPLER_AVG4_EN
            conv_cnt     <= '0;
            acc          <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= CS_SETUP;
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_last) begin
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        // Rising edge: edge_cnt[4:1] is the frame bit index.
                        if (!sclk && is_data_idx(edge_cnt[4:1])) begin
                            sr <= {sr[ADC_BITS-2:0], miso};
                        end
                        if (edge_cnt == EDGE_LAST) begin
                            state <= CS_HOLD;
                            cs_n  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (div_last) begin
                        div_cnt <= '0;
`ifdef SENSOR_SAMPLER_AVG4_EN
                        if (conv_cnt == 2'd3) begin
                            state        <= DONE;
                            sen          <= SEN_W'(sum_next[13:2]);
                            sample_valid <= 1'b1;
                            acc          <= '0;
                            conv_cnt     <= '0;
                        end else begin
                            state    <= CS_SETUP;
                            cs_n     <= 1'b0;
                            acc      <= sum_next;
                            conv_cnt <= conv_cnt + 1'b1;
                        end
`else
                        state        <= DONE;
                        sen          <= SEN_W'(sr);
                        sample_valid <= 1'b1;
`endif
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sensor_sampler.md
# sensor_sampler

Acquisition front end for the sensor-supervision path. It paces conversions on a fixed sample period and reads a 12-bit SPI ADC (MCP3201-style framing). Each sample is delivered as a zero-extended 16-bit `sen` word with a one-cycle `sample_valid` strobe. That strobe drives the `enable` input of each downstream per-sensor fault FSM, so those FSMs advance once per sample.

## Interface
Parameters:
- `SAMPLE_CYCLES`, 800000: clk cycles per sample period (16 ms at 50 MHz); must be ≥ 2.
- `SCLK_DIV`, 25: clk cycles per SCLK half-period; must be ≥ 1.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  reset, asynchronous, active-low
- `miso`  input  1  ADC serial data
- `cs_n`  output  1  ADC chip select, active-low
- `sclk`  output  1  ADC serial clock, idle low
- `sen`  output  16  last sample, zero-extended
- `sample_valid`  output  1  one-cycle strobe; `sen` is updated in the same cycle
- `busy`  output  1  high from frame start to the DONE cycle inclusive
- `overrun`  output  1  sticky; a tick arrived while busy

## Operation
- Reset (asynchronous, `rst`=0) forces `cs_n`=1, `sclk`=0, `sen`=0, `sample_valid`=0, `busy`=0, `overrun`=0, the tick counter to 0, and the FSM to IDLE.
- Tick generator:
  - The counter runs 0..`SAMPLE_CYCLES`-1 and wraps.
  - `tick` is high on the cycle the counter equals `SAMPLE_CYCLES`-1.
- FSM states:
  - IDLE: on `tick` → CS_SETUP, with `cs_n` going 0.
  - CS_SETUP: `SCLK_DIV` cycles → SHIFT.
  - SHIFT: 16 SCLK periods. `sclk` toggles every `SCLK_DIV` cycles, starting low. On each clk where `sclk` goes 0→1, `miso` is sampled into bit-index k = 0..15.
  - At the end of SHIFT: `cs_n` goes 1 → CS_HOLD.
  - CS_HOLD: `SCLK_DIV` cycles → DONE, or back to CS_SETUP when more conversions are pending (see Configuration).
  - DONE: one cycle. `sen` is registered and `sample_valid`=1, then → IDLE.
- Frame decode:
  - Indices 0–2 (sample, sample, null) are discarded.
  - Indices 3–14 are data, MSB first.
  - Index 15 is discarded.
  - `sen` = {4'b0, data[11:0]}.
- Tick arriving while not in IDLE: the tick is dropped, `overrun` is set to 1, and the current frame completes unchanged. `overrun` clears only on reset.
- `sen` holds its value between strobes.

## Timing
- Tick at cycle t:
  - `cs_n`=0 at t+1.
  - First `sclk` rise at t+2·`SCLK_DIV`+1.
  - `cs_n`=1 at t+33·`SCLK_DIV`+1.
  - `sample_valid`=1 at t+34·`SCLK_DIV`+1 (single-conversion latency).
- Per frame:
  - `cs_n` low for exactly 33·`SCLK_DIV` cycles.
  - Exactly 16 `sclk` rising edges.
  - `sclk`=0 whenever `cs_n`=1.
- `sample_valid` is never high for more than one consecutive cycle.
- Counter widths use `$clog2` of each terminal count.
- Reset mid-frame: outputs go to their reset values immediately. No `sample_valid` occurs until a full new period has elapsed after `rst` releases.

## Configuration
- `SENSOR_SAMPLER_AVG4_EN` defined:
  - Each tick runs 4 back-to-back conversions (CS_HOLD → CS_SETUP, 3 times).
  - The 12-bit results accumulate into a 14-bit sum.
  - `sen` = {4'b0, sum[13:2]} (truncating).
  - Latency = 4·34·`SCLK_DIV`+1.
  - Single strobe in DONE.
- Undefined: one conversion per tick. The accumulator and conversion counter are absent.

## Structure
- `sensor_pkg` holds:
  - `ADC_BITS`=12, `FRAME_BITS`=16, `DATA_FIRST_IDX`=3.
  - The sampler state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE).
  - `SEN_W`=16, shared with the downstream fault FSMs.
- One sub-module, `sample_tick_gen`: period counter → `tick`. Parameterised by `SAMPLE_CYCLES`; uses the same clk/rst.

## Test plan
Bench runs with `SAMPLE_CYCLES`=200 and `SCLK_DIV`=2 unless stated.
1. Reset: hold `rst`=0 mid-count → `cs_n`=1, `sclk`=0, `sen`=0, `sample_valid`=0, `busy`=0, `overrun`=0.
2. ADC model returns 350 → `sen`=16'd350.
   - `sample_valid` rises exactly 69 cycles after `tick`.
   - 16 `sclk` rises.
   - `cs_n` low for 66 cycles.
3. Successive frames return 0xFFF then 0x000 → `sen`=4095, then 0.
   - Strobes are exactly 200 cycles apart.
   - Index-15 and index-0..2 bits forced to 1 do not affect `sen`.
4. `SENSOR_SAMPLER_AVG4_EN`: conversions 100, 200, 300, 401 → `sen`=250.
   - One strobe, 273 cycles after `tick`.
   - 4 `cs_n` low pulses.
5. Overrun: `SAMPLE_CYCLES`=50 → second tick arrives while busy → `overrun`=1.
   - The frame still yields the correct `sen`.
   - The next conversion starts on the third tick.
   - `overrun` stays 1 until reset.
6. Assert `rst`=0 during SHIFT → `cs_n`=1 and `sclk`=0 in the same cycle (asynchronous).
   - After release, no `sample_valid` until 200+69 cycles.
